// File: rtl/regfile_bank_scheduler.sv
// regfile_bank_scheduler: ping-pong controller for a two-bank register file.
// One bank fills from the producer while the other drains to the consumer.
module regfile_bank_scheduler #(
  parameter int PORT_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wrValid,
  input  logic                  wrLast,
  input  logic [PORT_WIDTH-1:0] wrData0,
  input  logic [PORT_WIDTH-1:0] wrData1,
  output logic                  wrReady,
  output logic                  rfWriteBank,
  output logic                  rfWriteEnable,
  output logic [ADDR_WIDTH-2:0] rfWriteAddrTransferBlock,
  output logic [PORT_WIDTH-1:0] rfWriteData0,
  output logic [PORT_WIDTH-1:0] rfWriteData1,
  output logic                  rfReadBank,
  output logic [ADDR_WIDTH-1:0] rfReadAddr0,
  output logic [ADDR_WIDTH-1:0] rfReadAddr1,
  input  logic [PORT_WIDTH-1:0] rfReadData0,
  input  logic [PORT_WIDTH-1:0] rfReadData1,
  output logic                  rdValid,
  output logic                  rdLast,
  output logic [PORT_WIDTH-1:0] rdData0,
  output logic [PORT_WIDTH-1:0] rdData1,
  input  logic                  rdReady
);

  localparam int BW = ADDR_WIDTH - 1;
  localparam int NBLK = 1 << BW;
  localparam logic [BW-1:0] BLK_MAX = BW'(NBLK - 1);
  localparam logic [BW-1:0] BLK_ONE = BW'(1);
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE = ADDR_WIDTH'(1);

  logic                  w_bank;
  logic [BW-1:0]         w_blk;
  logic                  r_bank;
  logic [BW-1:0]         r_blk;
  logic [1:0]            full;
  logic [ADDR_WIDTH-1:0] blk_cnt [2];

  logic                  closing;
  logic                  closing_bank;
  logic                  in_flight;
  logic                  in_flight_last;

  logic [PORT_WIDTH-1:0] fifo_d0 [2];
  logic [PORT_WIDTH-1:0] fifo_d1 [2];
  logic [1:0]            fifo_last;
  logic                  fifo_head;
  logic [1:0]            fifo_occ;
  logic                  fifo_tail;

  logic                  accept;
  logic                  close_now;
  logic                  pop;
  logic                  push;
  logic [2:0]            pending;
  logic                  issue;
  logic                  issue_last;
  logic [1:0]            full_set;
  logic [1:0]            full_clr;

  // Write side handshake and bank-close detection.
  assign wrReady   = !reset && !full[w_bank] && !closing;
  assign accept    = wrValid && wrReady;
  assign close_now = accept && (wrLast || (w_blk == BLK_MAX));

  // Read side: FIFO plus in-flight read never exceeds two entries.
  assign rdValid    = (fifo_occ != 2'd0);
  assign pop        = rdValid && rdReady;
  assign push       = in_flight;
  assign pending    = {1'b0, fifo_occ} + {2'b00, in_flight} - {2'b00, pop};
  assign issue      = !reset && full[r_bank] && (pending < 3'd2);
  assign issue_last = ({1'b0, r_blk} == (blk_cnt[r_bank] - CNT_ONE));

  assign rfReadBank  = issue && r_bank;
  assign rfReadAddr0 = issue ? {r_blk, 1'b0} : '0;
  assign rfReadAddr1 = issue ? {r_blk, 1'b1} : '0;

  always_comb begin
    full_set = 2'b00;
    full_clr = 2'b00;
    if (closing) begin
      full_set[closing_bank] = 1'b1;
    end
    if (issue && issue_last) begin
      full_clr[r_bank] = 1'b1;
    end
  end

  assign fifo_tail = fifo_head ^ fifo_occ[0];
  assign rdData0   = fifo_d0[fifo_head];
  assign rdData1   = fifo_d1[fifo_head];
  assign rdLast    = rdValid && fifo_last[fifo_head];

  always_ff @(posedge clock) begin
    if (reset) begin
      w_bank                   <= 1'b0;
      w_blk                    <= '0;
      closing                  <= 1'b0;
      closing_bank             <= 1'b0;
      blk_cnt[0]               <= '0;
      blk_cnt[1]               <= '0;
      rfWriteEnable            <= 1'b0;
      rfWriteBank              <= 1'b0;
      rfWriteAddrTransferBlock <= '0;
      rfWriteData0             <= '0;
      rfWriteData1             <= '0;
    end else begin
      rfWriteEnable <= accept;
      closing       <= close_now;
      if (accept) begin
        rfWriteBank              <= w_bank;
        rfWriteAddrTransferBlock <= w_blk;
        rfWriteData0             <= wrData0;
        rfWriteData1             <= wrData1;
      end
      if (close_now) begin
        closing_bank     <= w_bank;
        blk_cnt[w_bank]  <= {1'b0, w_blk} + CNT_ONE;
        w_bank           <= !w_bank;
        w_blk            <= '0;
      end else if (accept) begin
        w_blk <= w_blk + BLK_ONE;
      end
    end
  end

  // Set wins: the closing write must never be lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      full <= 2'b00;
    end else begin
      full <= (full & ~full_clr) | full_set;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_bank         <= 1'b0;
      r_blk          <= '0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
    end else begin
      in_flight <= issue;
      if (issue) begin
        in_flight_last <= issue_last;
        if (issue_last) begin
          r_bank <= !r_bank;
          r_blk  <= '0;
        end else begin
          r_blk <= r_blk + BLK_ONE;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fifo_d0[0] <= '0;
      fifo_d0[1] <= '0;
      fifo_d1[0] <= '0;
      fifo_d1[1] <= '0;
      fifo_last  <= 2'b00;
      fifo_head  <= 1'b0;
      fifo_occ   <= 2'd0;
    end else begin
      if (push) begin
        fifo_d0[fifo_tail]   <= rfReadData0;
        fifo_d1[fifo_tail]   <= rfReadData1;
        fifo_last[fifo_tail] <= in_flight_last;
      end
      if (pop) begin
        fifo_head <= !fifo_head;
      end
      fifo_occ <= fifo_occ + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      full_collide: assert ((full_set & full_clr) == 2'b00);
      fifo_overflow: assert (!(push && !pop && (fifo_occ == 2'd2)));
    end
  end

endmodule

// File: tb/tb_regfile_bank_scheduler.sv
// Bench for regfile_bank_scheduler: behavioural regFile, queue-based
// reference model and one task per scenario.
module tb_regfile_bank_scheduler;

  localparam int PW   = 16;
  localparam int AW   = 3;
  localparam int NBLK = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          wrValid;
  logic          wrLast;
  logic [PW-1:0] wrData0;
  logic [PW-1:0] wrData1;
  logic          wrReady;
  logic          rfWriteBank;
  logic          rfWriteEnable;
  logic [AW-2:0] rfWriteAddrTransferBlock;
  logic [PW-1:0] rfWriteData0;
  logic [PW-1:0] rfWriteData1;
  logic          rfReadBank;
  logic [AW-1:0] rfReadAddr0;
  logic [AW-1:0] rfReadAddr1;
  logic [PW-1:0] rfReadData0;
  logic [PW-1:0] rfReadData1;
  logic          rdValid;
  logic          rdLast;
  logic [PW-1:0] rdData0;
  logic [PW-1:0] rdData1;
  logic          rdReady;

  always #5 clock = ~clock;

  regfile_bank_scheduler #(.PORT_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
    .clock(clock),
    .reset(reset),
    .wrValid(wrValid),
    .wrLast(wrLast),
    .wrData0(wrData0),
    .wrData1(wrData1),
    .wrReady(wrReady),
    .rfWriteBank(rfWriteBank),
    .rfWriteEnable(rfWriteEnable),
    .rfWriteAddrTransferBlock(rfWriteAddrTransferBlock),
    .rfWriteData0(rfWriteData0),
    .rfWriteData1(rfWriteData1),
    .rfReadBank(rfReadBank),
    .rfReadAddr0(rfReadAddr0),
    .rfReadAddr1(rfReadAddr1),
    .rfReadData0(rfReadData0),
    .rfReadData1(rfReadData1),
    .rdValid(rdValid),
    .rdLast(rdLast),
    .rdData0(rdData0),
    .rdData1(rdData1),
    .rdReady(rdReady)
  );

  // Two-bank regFile with synchronous read.
  logic [PW-1:0] rf [2][8];
  logic [PW-1:0] rf_q0;
  logic [PW-1:0] rf_q1;

  always @(posedge clock) begin
    if (rfWriteEnable) begin
      rf[rfWriteBank][{rfWriteAddrTransferBlock, 1'b0}] <= rfWriteData0;
      rf[rfWriteBank][{rfWriteAddrTransferBlock, 1'b1}] <= rfWriteData1;
    end
    rf_q0 <= rf[rfReadBank][rfReadAddr0];
    rf_q1 <= rf[rfReadBank][rfReadAddr1];
  end

  assign rfReadData0 = rf_q0;
  assign rfReadData1 = rf_q1;

  typedef struct packed {
    logic [PW-1:0] d0;
    logic [PW-1:0] d1;
    logic          last;
  } pair_t;

  typedef struct packed {
    logic          bank;
    logic [1:0]    blk;
    logic [PW-1:0] d0;
    logic [PW-1:0] d1;
  } wr_t;

  pair_t exp_q[$];
  pair_t obs_q[$];
  wr_t   wexp_q[$];
  wr_t   wobs_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int m_bank   = 0;
  int m_blk    = 0;
  int outstanding = 0;

  logic          s_wrready;
  logic          s_acc;
  logic          s_close;
  logic          s_rdvalid;
  logic          s_pop;
  logic          s_issue;
  logic          s_rbank;
  logic [AW-1:0] s_raddr0;
  pair_t         s_head;

  // Drive one cycle, sample mid-cycle, advance the reference model.
  task automatic tick(input logic wv, input logic wl, input logic rr,
                      input logic [PW-1:0] a, input logic [PW-1:0] b);
    pair_t p;
    wr_t   w;
    @(posedge clock);
    #1;
    wrValid = wv;
    wrLast  = wl;
    wrData0 = a;
    wrData1 = b;
    rdReady = rr;
    #1;
    cyc++;
    s_wrready = wrReady;
    s_acc     = wv && wrReady;
    s_close   = s_acc && (wl || (m_blk == NBLK - 1));
    s_rdvalid = rdValid;
    s_pop     = rdValid && rr;
    s_issue   = rfReadAddr1[0];
    s_rbank   = rfReadBank;
    s_raddr0  = rfReadAddr0;
    s_head    = '{rdData0, rdData1, rdLast};
    if (s_issue) outstanding++;
    if (s_pop) begin
      outstanding--;
      obs_q.push_back(s_head);
    end
    if (rfWriteEnable) begin
      w = '{rfWriteBank, rfWriteAddrTransferBlock, rfWriteData0, rfWriteData1};
      wobs_q.push_back(w);
    end
    if (s_acc) begin
      p = '{a, b, s_close};
      exp_q.push_back(p);
      w = '{m_bank[0], m_blk[1:0], a, b};
      wexp_q.push_back(w);
      if (s_close) begin
        m_bank = 1 - m_bank;
        m_blk  = 0;
      end else begin
        m_blk++;
      end
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    obs_q.delete();
    wexp_q.delete();
    wobs_q.delete();
    m_bank = 0;
    m_blk = 0;
    outstanding = 0;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset   = 1'b1;
    wrValid = 1'b0;
    wrLast  = 1'b0;
    wrData0 = '0;
    wrData1 = '0;
    rdReady = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    logic [63:0] outs;
    @(posedge clock);
    #1;
    reset   = 1'b1;
    wrValid = 1'b1;
    wrLast  = 1'b0;
    wrData0 = 16'h1234;
    wrData1 = 16'h5678;
    rdReady = 1'b1;
    #1;
    n_checks++;
    if (wrReady !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wrready_during got=%b exp=0", wrReady);
    end
    @(posedge clock);
    #1;
    reset   = 1'b0;
    wrValid = 1'b0;
    #1;
    n_checks++;
    if (wrReady !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_wrready_after got=%b exp=1", wrReady);
    end
    outs = {rfWriteBank, rfWriteEnable, rfWriteAddrTransferBlock,
            rfWriteData0, rfReadBank, rfReadAddr0, rfReadAddr1,
            rdValid, rdLast, rdData0[7:0], rfWriteData1[7:0], rdData1[7:0]};
    n_checks++;
    if (outs !== 64'd0 || rfWriteData1 !== '0 || rdData0 !== '0 || rdData1 !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=0", outs);
    end
    clear_model();
  endtask

  task automatic test_fill_drain();
    int acc_cyc;
    int first_v;
    pair_t e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0, 1'b1, 16'(2 * i), 16'(2 * i + 1));
      n_checks++;
      if (s_acc !== 1'b1) begin
        n_fail++;
        $display("FAIL fill_accept i=%0d got=%b exp=1", i, s_acc);
      end
    end
    acc_cyc = cyc;
    first_v = -1;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0, 1'b1, '0, '0);
      if (s_rdvalid && first_v < 0) first_v = cyc;
    end
    n_checks++;
    if (first_v - acc_cyc - 1 !== 3) begin
      n_fail++;
      $display("FAIL fill_latency got=%0d exp=3 (first_v=%0d)", first_v - acc_cyc - 1, first_v);
    end
    n_checks++;
    if (obs_q.size() !== 4 || wobs_q.size() !== 4) begin
      n_fail++;
      $display("FAIL fill_count got=%0d/%0d exp=4/4", obs_q.size(), wobs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        e = '{16'(2 * i), 16'(2 * i + 1), (i == 3)};
        n_checks++;
        if (obs_q[i] !== e) begin
          n_fail++;
          $display("FAIL fill_pair i=%0d got=%h exp=%h", i, obs_q[i], e);
        end
        n_checks++;
        if (wobs_q[i].bank !== 1'b0 || wobs_q[i].blk !== 2'(i)) begin
          n_fail++;
          $display("FAIL fill_wr_addr i=%0d got=%b/%0d exp=0/%0d",
                   i, wobs_q[i].bank, wobs_q[i].blk, i);
        end
      end
    end
  endtask

  task automatic test_early_close();
    pair_t e0;
    pair_t e1;
    do_reset();
    tick(1'b1, 1'b0, 1'b1, 16'd10, 16'd11);
    tick(1'b1, 1'b1, 1'b1, 16'd12, 16'd13);
    for (int i = 0; i < 15; i++) tick(1'b0, 1'b0, 1'b1, '0, '0);
    e0 = '{16'd10, 16'd11, 1'b0};
    e1 = '{16'd12, 16'd13, 1'b1};
    n_checks++;
    if (obs_q.size() !== 2) begin
      n_fail++;
      $display("FAIL early_count got=%0d exp=2", obs_q.size());
    end else begin
      n_checks++;
      if (obs_q[0] !== e0 || obs_q[1] !== e1) begin
        n_fail++;
        $display("FAIL early_pairs got=%h,%h exp=%h,%h", obs_q[0], obs_q[1], e0, e1);
      end
    end
    tick(1'b1, 1'b0, 1'b1, 16'(($urandom)), 16'($urandom));
    tick(1'b0, 1'b0, 1'b1, '0, '0);
    n_checks++;
    if (wobs_q.size() !== 3 || wobs_q[2].bank !== 1'b1 || wobs_q[2].blk !== 2'd0) begin
      n_fail++;
      $display("FAIL early_next_bank got=%0d writes, last=%h exp bank1 blk0",
               wobs_q.size(), wobs_q[wobs_q.size() - 1]);
    end
  endtask

  task automatic test_backpressure();
    int acc_n;
    int acc9;
    int last_iss;
    logic [PW-1:0] da;
    logic [PW-1:0] db;
    do_reset();
    acc_n = 0;
    for (int i = 0; i < 40 && acc_n < 8; i++) begin
      tick(1'b1, 1'b0, 1'b0, 16'($urandom), 16'($urandom));
      if (s_acc) acc_n++;
    end
    n_checks++;
    if (acc_n !== 8) begin
      n_fail++;
      $display("FAIL bp_fill got=%0d exp=8", acc_n);
    end
    da = 16'($urandom);
    db = 16'($urandom);
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0, 1'b0, da, db);
      if (s_acc) acc_n++;
      n_checks++;
      if (s_wrready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_wrready i=%0d got=%b exp=0", i, s_wrready);
      end
      n_checks++;
      if (s_rdvalid !== 1'b1 || s_head !== exp_q[0]) begin
        n_fail++;
        $display("FAIL bp_hold i=%0d got=%b/%h exp=1/%h", i, s_rdvalid, s_head, exp_q[0]);
      end
    end
    acc9 = -1;
    last_iss = -1;
    for (int i = 0; i < 20 && acc_n < 9; i++) begin
      tick(1'b1, 1'b0, 1'b1, da, db);
      if (s_issue && s_rbank == 1'b0 && s_raddr0 == 3'd6) last_iss = cyc;
      if (s_acc) begin
        acc_n++;
        acc9 = cyc;
      end
    end
    n_checks++;
    if (acc9 < 0 || last_iss < 0 || acc9 - last_iss !== 1) begin
      n_fail++;
      $display("FAIL bp_ninth_accept got=%0d exp=1 (acc9=%0d iss=%0d)",
               acc9 - last_iss, acc9, last_iss);
    end
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 1'b1, '0, '0);
    n_checks++;
    if (obs_q.size() !== 8 || exp_q.size() !== 9) begin
      n_fail++;
      $display("FAIL bp_count got=%0d/%0d exp=8/9", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL bp_pair i=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_toggle();
    int acc_n;
    logic rr;
    logic wv;
    logic wl;
    logic prev_stall;
    pair_t prev_head;
    do_reset();
    acc_n = 0;
    prev_stall = 1'b0;
    prev_head = '0;
    for (int i = 0; i < 300 && (acc_n < 16 || obs_q.size() < 16); i++) begin
      rr = (i % 2 == 0);
      wv = (acc_n < 16);
      wl = (acc_n == 15) || ($urandom_range(0, 4) == 0);
      tick(wv, wl, rr, 16'($urandom), 16'($urandom));
      if (s_acc) acc_n++;
      n_checks++;
      if (outstanding > 2 || outstanding < 0) begin
        n_fail++;
        $display("FAIL toggle_occupancy cyc=%0d got=%0d exp<=2", cyc, outstanding);
      end
      if (prev_stall) begin
        n_checks++;
        if (s_rdvalid !== 1'b1 || s_head !== prev_head) begin
          n_fail++;
          $display("FAIL toggle_stable cyc=%0d got=%b/%h exp=1/%h",
                   cyc, s_rdvalid, s_head, prev_head);
        end
      end
      prev_stall = s_rdvalid && !rr;
      prev_head = s_head;
    end
    n_checks++;
    if (obs_q.size() !== 16 || exp_q.size() !== 16) begin
      n_fail++;
      $display("FAIL toggle_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL toggle_pair i=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    n_checks++;
    if (wobs_q.size() !== wexp_q.size()) begin
      n_fail++;
      $display("FAIL toggle_wr_count got=%0d exp=%0d", wobs_q.size(), wexp_q.size());
    end else begin
      for (int i = 0; i < wexp_q.size(); i++) begin
        n_checks++;
        if (wobs_q[i] !== wexp_q[i]) begin
          n_fail++;
          $display("FAIL toggle_wr i=%0d got=%h exp=%h", i, wobs_q[i], wexp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] outs;
    for (int i = 0; i < 0; i++) begin end
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b1, 16'($urandom), 16'($urandom));
    for (int i = 0; i < 30 && obs_q.size() < 2; i++) tick(1'b0, 1'b0, 1'b1, '0, '0);
    n_checks++;
    if (obs_q.size() !== 2) begin
      n_fail++;
      $display("FAIL midrst_halfway got=%0d exp=2", obs_q.size());
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (wrReady !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_wrready_during got=%b exp=0", wrReady);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    outs = {rfWriteBank, rfWriteEnable, rfWriteAddrTransferBlock,
            rfReadBank, rfReadAddr0, rfReadAddr1, rdValid, rdLast, 16'd0};
    n_checks++;
    if (outs !== 32'd0 || rfWriteData0 !== '0 || rfWriteData1 !== '0 ||
        rdData0 !== '0 || rdData1 !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs got=%h exp=0", outs);
    end
    n_checks++;
    if (wrReady !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_wrready_after got=%b exp=1", wrReady);
    end
    clear_model();
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b1, 16'($urandom), 16'($urandom));
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 1'b1, '0, '0);
    n_checks++;
    if (wobs_q.size() !== 4 || wobs_q[0] !== wexp_q[0] || wobs_q[0].bank !== 1'b0 ||
        wobs_q[0].blk !== 2'd0) begin
      n_fail++;
      $display("FAIL midrst_first_write got=%h exp=%h", wobs_q[0], wexp_q[0]);
    end
    n_checks++;
    if (obs_q.size() !== 4) begin
      n_fail++;
      $display("FAIL midrst_count got=%0d exp=4", obs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL midrst_pair i=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  // Writer only pauses for the single cycle after each bank close.
  task automatic test_stream();
    int acc_n;
    int first_acc;
    int last_acc;
    logic wv;
    logic prev_close;
    do_reset();
    acc_n = 0;
    first_acc = -1;
    last_acc = -1;
    prev_close = 1'b0;
    for (int i = 0; i < 400 && (acc_n < 64 || obs_q.size() < 64); i++) begin
      wv = (acc_n < 64);
      tick(wv, 1'b0, 1'b1, 16'($urandom), 16'($urandom));
      if (wv) begin
        n_checks++;
        if (s_wrready !== !prev_close) begin
          n_fail++;
          $display("FAIL stream_wrready cyc=%0d got=%b exp=%b", cyc, s_wrready, !prev_close);
        end
      end
      prev_close = s_close;
      if (s_acc) begin
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        acc_n++;
      end
    end
    n_checks++;
    if (acc_n !== 64 || last_acc - first_acc !== 78) begin
      n_fail++;
      $display("FAIL stream_span got=%0d accepts over %0d exp=64 over 78",
               acc_n, last_acc - first_acc);
    end
    n_checks++;
    if (obs_q.size() !== 64) begin
      n_fail++;
      $display("FAIL stream_count got=%0d exp=64", obs_q.size());
    end else begin
      for (int i = 0; i < 64; i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL stream_pair i=%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    wrValid = 1'b0;
    wrLast  = 1'b0;
    wrData0 = '0;
    wrData1 = '0;
    rdReady = 1'b0;
    test_reset();
    test_fill_drain();
    test_early_close();
    test_backpressure();
    test_toggle();
    test_reset_mid();
    test_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
